neokeon_data_out_serializer: RTL

Downstream stage of the Neokeon 128-bit output data register. Captures the 128-bit ciphertext/plaintext block when the register is written, then emits it as a sequence of narrow words over a valid/ready stream interface toward the host bus or UART/SPI wrapper. Supports back-to-back blocks and flags blocks that arrive while a transfer is still in progress.

---
 rtl/neokeon_data_out_serializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/neokeon_data_out_serializer.sv
// Serializes a captured 128-bit Neokeon output block into WORD_W-bit words over
// a valid/ready stream; flags blocks that arrive while a transfer is pending.
module neokeon_data_out_serializer #(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              inClk,
  input  logic              inRst,
  input  logic              inLoad,
  input  logic [127:0]      inData,
  output logic [WORD_W-1:0] outWord,
  output logic              outValid,
  input  logic              inReady,
  output logic              outLast,
  output logic              outBusy,
  output logic              outOverrun,
  input  logic              inClrErr
);

  localparam int N  = 128 / WORD_W;
  localparam int CW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          r_state;
  logic [127:0]    r_shift;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_nxt;
  logic [127:0]    w_shift_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_xfer;
  logic            w_final_xfer;
  logic            w_set_ovr;
  logic            w_ovr_nxt;
  logic [WORD_W-1:0] w_lead_nxt;

  assign w_xfer       = (r_state == SEND) && inReady;
  assign w_final_xfer = w_xfer && (r_cnt == '0);

  // Next-state, shift register and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_set_ovr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (inLoad) begin
          w_shift_nxt = inData;
          w_cnt_nxt   = CW'(N - 1);
          w_state_nxt = SEND;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SEND: begin
        if (w_final_xfer) begin
          if (inLoad) begin
            w_shift_nxt = inData;
            w_cnt_nxt   = CW'(N - 1);
            w_state_nxt = SEND;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_shift_nxt = MSB_FIRST ? (r_shift << WORD_W) : (r_shift >> WORD_W);
          w_cnt_nxt   = r_cnt - CW'(1);
        end else begin
          w_state_nxt = SEND;
        end
        // Any load in SEND that is not the back-to-back slot is dropped.
        if (inLoad && !w_final_xfer) begin
          w_set_ovr = 1'b1;
        end else begin
          w_set_ovr = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  always_comb begin
    w_lead_nxt = MSB_FIRST ? w_shift_nxt[127 -: WORD_W] : w_shift_nxt[WORD_W-1:0];
    w_ovr_nxt  = w_set_ovr | (outOverrun & ~inClrErr);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      outWord    <= '0;
      outValid   <= 1'b0;
      outLast    <= 1'b0;
      outBusy    <= 1'b0;
      outOverrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      outWord    <= (w_state_nxt == SEND) ? w_lead_nxt : '0;
      outValid   <= (w_state_nxt == SEND);
      outBusy    <= (w_state_nxt == SEND);
      outLast    <= (w_state_nxt == SEND) && (w_cnt_nxt == '0);
      outOverrun <= w_ovr_nxt;
    end
  end

endmodule
